// File: rtl/saw_voice_scheduler.sv
// saw_voice_scheduler
// Shares one registered saw wavetable LUT across NUM_CH voices. Each sample
// tick starts a frame that visits every voice in turn: issue the LUT address
// from the pre-increment phase, wait one cycle for the LUT, then capture the
// result, scale it by the voice volume and strobe it out to the mixer.
module saw_voice_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int PHASE_W = 24,
   parameter int CH_W    = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      sample_tick,
   input  logic                      cfg_we,
   input  logic                      cfg_phase_rst,
   input  logic [CH_W-1:0]           cfg_ch,
   input  logic [PHASE_W-1:0]        cfg_incr,
   input  logic [7:0]                cfg_vol,
   input  logic                      cfg_enable,
   output logic [8:0]                lut_addr,
   input  logic signed [15:0]        lut_data,
   output logic                      out_valid,
   output logic [CH_W-1:0]           out_ch,
   output logic signed [15:0]        out_sample,
   output logic                      busy,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      CAPTURE
   } state_t;

   state_t              state;
   logic [CH_W-1:0]     ch;

   logic [PHASE_W-1:0]  phase [NUM_CH];
   logic [PHASE_W-1:0]  incr  [NUM_CH];
   logic [7:0]          vol   [NUM_CH];
   logic [NUM_CH-1:0]   en;

   logic                cfg_hit;
   logic signed [24:0]  prod;

   // Config target decode and volume scaling of the current LUT word
   always_comb begin
      cfg_hit = (int'(cfg_ch) < NUM_CH);
      prod    = $signed(lut_data) * $signed({1'b0, vol[ch]});
   end

   // Frame sequencer: walks voices through ISSUE -> WAIT -> CAPTURE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ch         <= '0;
         lut_addr   <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_sample <= '0;
         busy       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (sample_tick) begin
                  ch    <= '0;
                  busy  <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               lut_addr <= phase[ch][PHASE_W-1 -: 9];
               state    <= WAIT;
            end
            WAIT: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               out_valid  <= 1'b1;
               out_ch     <= ch;
               out_sample <= en[ch] ? prod[23:8] : '0;
               if (ch == CH_W'(NUM_CH - 1)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  ch    <= ch + 1'b1;
                  state <= ISSUE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Sticky overrun flag; a tick while busy takes priority over the clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (sample_tick && (state != IDLE)) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

   // Per-voice config and phase accumulators
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < unsigned'(NUM_CH); i++) begin
            phase[i] <= '0;
            incr[i]  <= '0;
            vol[i]   <= '0;
         end
         en <= '0;
      end else begin
         if (cfg_we && cfg_hit) begin
            incr[cfg_ch] <= cfg_incr;
            vol[cfg_ch]  <= cfg_vol;
            en[cfg_ch]   <= cfg_enable;
         end
         if ((state == ISSUE) && en[ch]) begin
            phase[ch] <= phase[ch] + incr[ch];
         end
         // Placed last so a coincident phase reset overrides the ISSUE advance
         if (cfg_phase_rst && cfg_hit) begin
            phase[cfg_ch] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_saw_voice_scheduler.sv
// tb_saw_voice_scheduler
// Directed plus randomized checks of saw_voice_scheduler against a per-frame
// reference model of voice phases, volumes and enables.
module tb_saw_voice_scheduler;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                sample_tick;
   logic                cfg_we;
   logic                cfg_phase_rst;
   logic [1:0]          cfg_ch;
   logic [23:0]         cfg_incr;
   logic [7:0]          cfg_vol;
   logic                cfg_enable;
   logic [8:0]          lut_addr;
   logic signed [15:0]  lut_data;
   logic                out_valid;
   logic [1:0]          out_ch;
   logic signed [15:0]  out_sample;
   logic                busy;
   logic                overrun;
   logic                overrun_clr;

   // second instance with a non power-of-two voice count
   logic                tick2;
   logic                we2;
   logic [2:0]          ch2;
   logic                prst2;
   logic [8:0]          lut_addr2;
   logic signed [15:0]  lut_data2;
   logic                out_valid2;
   logic [2:0]          out_ch2;
   logic signed [15:0]  out_sample2;
   logic                busy2;
   logic                overrun2;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   saw_voice_scheduler #(.NUM_CH(4), .PHASE_W(24), .CH_W(2)) dut (
      .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
      .cfg_we(cfg_we), .cfg_phase_rst(cfg_phase_rst), .cfg_ch(cfg_ch),
      .cfg_incr(cfg_incr), .cfg_vol(cfg_vol), .cfg_enable(cfg_enable),
      .lut_addr(lut_addr), .lut_data(lut_data), .out_valid(out_valid),
      .out_ch(out_ch), .out_sample(out_sample), .busy(busy),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   saw_voice_scheduler #(.NUM_CH(5), .PHASE_W(24), .CH_W(3)) dut2 (
      .clk(clk), .reset_n(reset_n), .sample_tick(tick2),
      .cfg_we(we2), .cfg_phase_rst(prst2), .cfg_ch(ch2),
      .cfg_incr(cfg_incr), .cfg_vol(cfg_vol), .cfg_enable(cfg_enable),
      .lut_addr(lut_addr2), .lut_data(lut_data2), .out_valid(out_valid2),
      .out_ch(out_ch2), .out_sample(out_sample2), .busy(busy2),
      .overrun(overrun2), .overrun_clr(1'b0)
   );

   // Saw table: linear ramp from -32768 at address 0 through 0 at 256
   function automatic int saw_i(input int a);
      return (a - 256) * 128;
   endfunction

   function automatic logic signed [15:0] saw(input logic [8:0] a);
      return 16'(saw_i(int'(a)));
   endfunction

   // Registered LUT models: data follows address by one clock
   always @(posedge clk) begin
      lut_data  <= saw(lut_addr);
      lut_data2 <= saw(lut_addr2);
   end

   // reference model state
   int unsigned m_phase [4];
   int unsigned m_incr  [4];
   int          m_vol   [4];
   bit          m_en    [4];
   bit          m_ovr;
   int          last_addr [4];
   int          last_samp [4];

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_phase[i] = 0; m_incr[i] = 0; m_vol[i] = 0; m_en[i] = 0;
      end
      m_ovr = 0;
   endtask

   // Idle-time config write to the 4-voice instance
   task automatic cfg_write(input int c, input int unsigned inc, input int v,
                            input bit e, input bit prst);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = 2'(c); cfg_incr = 24'(inc);
      cfg_vol = 8'(v); cfg_enable = e; cfg_phase_rst = prst;
      @(negedge clk);
      cfg_we = 1'b0; cfg_phase_rst = 1'b0;
      m_incr[c] = inc & 32'hFF_FFFF; m_vol[c] = v; m_en[c] = e;
      if (prst) m_phase[c] = 0;
   endtask

   task automatic drive_ctl(input int cyc, input int xtick, input int xclr,
                            input int xprst);
      sample_tick   = (cyc == xtick);
      overrun_clr   = (cyc == xclr);
      cfg_phase_rst = (cyc == xprst);
      if (cyc == xprst) cfg_ch = 2'd0;
   endtask

   // One frame: optional mid-frame tick, overrun clear and voice-0 phase reset,
   // each asserted for the cycle following the given edge count (-1 = none)
   task automatic run_frame(input int xtick, input int xclr, input int xprst);
      int ea [4];
      int es [4];
      int cyc;
      int got;
      for (int k = 0; k < 4; k++) begin
         ea[k] = int'((m_phase[k] >> 15) & 32'h1FF);
         es[k] = m_en[k] ? ((saw_i(ea[k]) * m_vol[k]) >>> 8) : 0;
      end
      @(negedge clk);
      sample_tick = 1'b1;
      @(posedge clk); #1;
      cyc = 0; got = 0;
      drive_ctl(cyc, xtick, xclr, xprst);
      while (got < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         drive_ctl(cyc, xtick, xclr, xprst);
         if (out_valid === 1'b1) begin
            chk("out_ch", out_ch, got);
            chk("lut_addr", lut_addr, ea[got]);
            chk("out_sample", out_sample, es[got]);
            last_addr[got] = int'(lut_addr);
            last_samp[got] = int'(out_sample);
            if (got == 0) begin
               chk("first_latency", cyc, 3);
               chk("busy_mid", busy, 1);
            end
            if (got == 3) chk("busy_end", busy, 0);
            got++;
         end
      end
      sample_tick = 1'b0; overrun_clr = 1'b0; cfg_phase_rst = 1'b0;
      chk("valid_count", got, 4);
      if (xtick >= 0) m_ovr = 1;
      else if (xclr >= 0) m_ovr = 0;
      for (int k = 0; k < 4; k++)
         if (m_en[k]) m_phase[k] = (m_phase[k] + m_incr[k]) & 32'hFF_FFFF;
      if (xprst >= 0) m_phase[0] = 0;
      @(posedge clk); #1;
      chk("no_extra_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("overrun", overrun, m_ovr);
   endtask

   initial begin
      int cyc;
      int got;
      reset_n = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0; cfg_phase_rst = 1'b0;
      cfg_ch = '0; cfg_incr = '0; cfg_vol = '0; cfg_enable = 1'b0;
      overrun_clr = 1'b0;
      tick2 = 1'b0; we2 = 1'b0; ch2 = '0; prst2 = 1'b0;
      model_reset();

      // reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst_lut_addr", lut_addr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_out_sample", out_sample, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      @(negedge clk) reset_n = 1'b1;

      // basic frames and phase advance
      cfg_write(0, 32'h008000, 255, 1, 0);
      run_frame(-1, -1, -1);
      chk("tp_addr0", last_addr[0], 0);
      chk("tp_samp0", last_samp[0], -32640);
      chk("tp_samp1", last_samp[1], 0);
      chk("tp_samp3", last_samp[3], 0);
      run_frame(-1, -1, -1);
      chk("tp2_addr0", last_addr[0], 1);
      chk("tp2_samp0", last_samp[0], -32513);
      cfg_write(0, 32'h7F0000, 255, 1, 0);
      run_frame(-1, -1, -1);
      cfg_write(0, 32'h800000, 255, 1, 0);
      run_frame(-1, -1, -1);
      chk("half_addr", last_addr[0], 256);
      chk("half_samp", last_samp[0], 0);
      run_frame(-1, -1, -1);
      chk("wrap_addr", last_addr[0], 0);
      chk("wrap_samp", last_samp[0], -32640);

      // overrun: mid-frame tick, clear, last-CAPTURE tick, clear racing set
      run_frame(5, -1, -1);
      chk("ovr_set", overrun, 1);
      @(negedge clk) overrun_clr = 1'b1;
      @(negedge clk) overrun_clr = 1'b0;
      m_ovr = 0;
      chk("ovr_clr", overrun, 0);
      run_frame(11, -1, -1);
      @(negedge clk) overrun_clr = 1'b1;
      @(negedge clk) overrun_clr = 1'b0;
      m_ovr = 0;
      chk("ovr_clr2", overrun, 0);
      run_frame(5, 5, -1);
      chk("ovr_set_wins", overrun, 1);

      // phase reset coinciding with voice 0 ISSUE
      cfg_write(0, 32'h123400, 255, 1, 0);
      run_frame(-1, -1, -1);
      run_frame(-1, -1, 0);
      run_frame(-1, -1, -1);
      chk("prst_addr", last_addr[0], 0);

      // volume scaling, zero volume, disabled voice freezes phase
      cfg_write(1, 32'hC00000, 128, 1, 1);
      run_frame(-1, -1, -1);
      chk("vol128_a0", last_samp[1], -16384);
      run_frame(-1, -1, -1);
      chk("vol128_addr", last_addr[1], 384);
      chk("vol128_samp", last_samp[1], 8192);
      cfg_write(1, 32'h400000, 0, 1, 0);
      run_frame(-1, -1, -1);
      run_frame(-1, -1, -1);
      chk("vol0_addr", last_addr[1], 384);
      chk("vol0_samp", last_samp[1], 0);
      cfg_write(1, 32'h400000, 255, 0, 0);
      run_frame(-1, -1, -1);
      run_frame(-1, -1, -1);
      chk("dis_addr", last_addr[1], 0);
      chk("dis_samp", last_samp[1], 0);
      cfg_write(1, 32'h400000, 255, 1, 0);
      run_frame(-1, -1, -1);
      chk("reen_samp", last_samp[1], -32640);

      // randomized config between frames
      for (int f = 0; f < 15; f++) begin
         int nw;
         nw = $urandom_range(0, 2);
         for (int w = 0; w < nw; w++)
            cfg_write($urandom_range(0, 3), $urandom & 32'hFF_FFFF,
                      $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0));
         run_frame(-1, -1, -1);
      end

      // reset during WAIT
      cfg_write(0, 32'h400000, 200, 1, 1);
      run_frame(-1, -1, -1);
      @(negedge clk) sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      @(posedge clk); #1;
      chk("wait_addr", lut_addr, 128);
      reset_n = 1'b0;
      #1;
      chk("arst_lut_addr", lut_addr, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_ch", out_ch, 0);
      chk("arst_out_sample", out_sample, 0);
      chk("arst_busy", busy, 0);
      chk("arst_overrun", overrun, 0);
      model_reset();
      @(negedge clk) reset_n = 1'b1;
      run_frame(-1, -1, -1);
      chk("post_rst_samp0", last_samp[0], 0);

      // 5-voice instance: out-of-range writes ignored, voice 4 usable
      @(negedge clk);
      we2 = 1'b1; ch2 = 3'd5; cfg_incr = 24'h100000; cfg_vol = 8'd255; cfg_enable = 1'b1;
      @(negedge clk) ch2 = 3'd7;
      @(negedge clk) begin ch2 = 3'd4; cfg_incr = 24'h000000; end
      @(negedge clk) we2 = 1'b0;
      tick2 = 1'b1;
      @(posedge clk); #1 tick2 = 1'b0;
      cyc = 0; got = 0;
      while (got < 5 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (out_valid2 === 1'b1) begin
            chk("n5_ch", out_ch2, got);
            chk("n5_samp", out_sample2, (got == 4) ? -32640 : 0);
            got++;
         end
      end
      chk("n5_count", got, 5);
      chk("n5_frame_len", cyc, 15);
      chk("n5_busy_end", busy2, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/saw_voice_scheduler.md
Name: saw_voice_scheduler

Overview:
- Time-multiplexes one shared saw wavetable LUT across NUM_CH tracker voices.
- On each audio sample tick it walks every voice in order: it advances the voice's phase accumulator, issues the LUT address, captures the LUT result and applies per-voice volume.
- It then emits one scaled sample per voice to the downstream mixer.
- It sits between the tracker pattern/register logic (config writes) and the mixer.

Parameters:
- NUM_CH, 4, number of voices; legal range 1-16.
- PHASE_W, 24, phase accumulator width; LUT address is phase[PHASE_W-1 -: 9].
- CH_W, 2, voice index width; must equal clog2(NUM_CH), minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_tick  in  1  one-cycle pulse; starts a frame.
- cfg_we  in  1  write incr/vol/enable of voice cfg_ch.
- cfg_phase_rst  in  1  zero the phase of voice cfg_ch.
- cfg_ch  in  CH_W  target voice.
- cfg_incr  in  PHASE_W  phase increment per tick.
- cfg_vol  in  8  unsigned volume.
- cfg_enable  in  1  voice enable.
- lut_addr  out  9  address to the saw LUT.
- lut_data  in  16  signed LUT output; registered inside the LUT, one clock after lut_addr.
- out_valid  out  1  one-cycle sample strobe.
- out_ch  out  CH_W  voice of out_sample.
- out_sample  out  16  signed scaled sample.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  sticky: tick arrived while busy.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (reset_n low, async): state IDLE; all phase, incr, vol and enable are 0; lut_addr=0, out_valid=0, out_ch=0, out_sample=0, busy=0, overrun=0, channel counter=0.
- FSM states:
  - IDLE: on sample_tick, set ch=0, go to ISSUE.
  - ISSUE: register lut_addr <= phase[ch] top 9 bits. If enable[ch], phase[ch] <= phase[ch]+incr[ch] (mod 2^PHASE_W, wraps silently). Go to WAIT.
  - WAIT: the LUT registers its output. Go to CAPTURE.
  - CAPTURE: out_valid=1 for this cycle only; out_ch=ch; out_sample = enable[ch] ? (lut_data * {1'b0,cfg'd vol}) >>> 8 (take bits [23:8] of the 25-bit signed product) : 0. If ch==NUM_CH-1 go to IDLE, else ch+1 and go to ISSUE.
- Timing: 3 cycles per voice, so a frame is 3*NUM_CH cycles. First out_valid comes 3 cycles after the tick edge. Samples of a voice use the pre-increment phase.
- busy=1 in ISSUE, WAIT and CAPTURE; busy=0 only in IDLE. A tick arriving in the last CAPTURE cycle counts as an overrun.
- sample_tick while busy is ignored (the frame is not restarted) and sets overrun. overrun_clr clears it. If both happen in the same cycle, set wins.
- Config writes are accepted in any state. Writes with cfg_ch >= NUM_CH are ignored.
- If ISSUE for voice k coincides with cfg_we to k, the phase update uses the old incr and the new incr is stored for the next tick.
- If cfg_phase_rst coincides with the ISSUE phase update of the same voice, the reset wins and phase=0.
- cfg_we and cfg_phase_rst may be asserted together; both take effect.
- Config changes during WAIT/CAPTURE of voice k affect that voice's current out_sample volume/enable; they are sampled in CAPTURE.
- lut_addr holds its last value outside ISSUE.
- Outputs out_ch and out_sample hold their values when out_valid=0.

Test Plan:
- Reset, then NUM_CH=4, voice0 enable, vol=255, incr=0x008000, phase 0, tick → first out_valid at cycle 3: out_ch=0, lut_addr=0, out_sample=(-32768*255)>>>8=-32640. Voices 1-3 give out_sample=0 at cycles 6, 9, 12. busy falls after cycle 12.
- Second tick on voice0 → lut_addr=1, LUT=-32640, out_sample=-32513. Set incr=0x800000 with phase at 0x800000 → lut_addr=256, out_sample=0. Next tick wraps phase to 0.
- Tick while busy in mid-frame → frame completes unchanged with exactly 4 out_valid. overrun=1 until overrun_clr; overrun_clr together with a new overrun keeps it 1.
- cfg_phase_rst to voice0 in the same cycle as voice0's ISSUE → phase reads 0 at the next tick (lut_addr=0). cfg_we with cfg_ch=5 changes nothing.
- vol=128, LUT addr 384 (data 16384) → out_sample=8192. vol=0 → 0. Disabled voice → 0 and phase frozen.
- Assert reset_n low during WAIT → all outputs go to 0 immediately and busy=0. After release, a tick starts cleanly from voice 0 with all voices disabled.
